// File: rtl/keypad_pkg.sv
// Shared types and helpers for the matrix keypad scanner: FSM states, key-code math, counter sizing.
// Pure declarations; no logic, no latency.
package keypad_pkg;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_HOLD, S_RELS} state_t;

  // Cycles a row change needs to reach the FSM through the input synchronizer.
  localparam int SYNC_LAT = 2;

  function automatic int code_w(input int rows, input int cols);
    return $clog2(rows * cols);
  endfunction

  function automatic int cnt_w(input int deb_cyc, input int rpt_dly);
    return $clog2(((deb_cyc > rpt_dly) ? deb_cyc : rpt_dly) + 1);
  endfunction

  function automatic int code_of(input int row, input int col, input int cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Column synchronizer plus a stability counter for a caller-selected column condition.
// 2-cycle input latency; stable asserts once the condition has held DEB_CYC consecutive cycles; never stalls.
module keypad_debounce #(
  parameter int COLS    = 4,
  parameter int DEB_CYC = 250000,
  parameter int CW      = 18
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [COLS-1:0] key_v,
  input  logic [COLS-1:0] col_mask,
  input  logic            want_low,
  output logic [COLS-1:0] cols,
  output logic            any_low,
  output logic            stable
);

  logic [COLS-1:0] sync1;
  logic [CW-1:0]   cnt;
  logic            cond;

  // Pins idle high, so the synchronizer resets to "nothing pressed".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '1;
      cols  <= '1;
    end else begin
      sync1 <= key_v;
      cols  <= sync1;
    end
  end

  assign any_low = |(~cols);

  // want_low: any masked column low; otherwise: every masked column high.
  // An empty mask with want_low set is never true, which parks the counter at zero.
  assign cond = want_low ? |(~cols & col_mask) : &(cols | ~col_mask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!cond) begin
      cnt <= '0;
    end else if (cnt != CW'(DEB_CYC)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign stable = cond && (cnt == CW'(DEB_CYC));

endmodule

// File: rtl/matrix_keypad_scanner.sv
// ROWSxCOLS keypad scanner: debounce, one-hot-low row scan, hold/release tracking, auto-repeat, key history.
// Press-to-key_valid is sync + DEB_CYC + per-row settle; outputs are registered pulses with no backpressure.
module matrix_keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int DEB_CYC = 250000,
  parameter int SETTLE  = 8,
  parameter int RPT_DLY = 12500000,
  parameter int RPT_PER = 2500000,
  parameter int DIGITS  = 4
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [COLS-1:0]                          key_v,
  output logic [ROWS-1:0]                          key_h,
  input  logic                                     rpt_en,
  input  logic                                     disp_clr,
  output logic                                     key_valid,
  output logic [code_w(ROWS, COLS)-1:0]            key_code,
  output logic                                     key_down,
  output logic                                     key_release,
  output logic [DIGITS*code_w(ROWS, COLS)-1:0]     disp_num
);

  localparam int CODE_W = code_w(ROWS, COLS);
  localparam int DW     = DIGITS * CODE_W;
  localparam int CW     = cnt_w(DEB_CYC, RPT_DLY);
  localparam int RW     = $clog2(ROWS);
  localparam int CCW    = $clog2(COLS);
  // A freshly driven row is only trustworthy once it has crossed the synchronizer and settled.
  localparam int SAMPLE_AT = SETTLE + SYNC_LAT - 1;

  state_t          state;
  logic [RW-1:0]   row;
  logic [CCW-1:0]  col_q;
  logic [CCW-1:0]  hit_col;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   rpt_tgt;
  logic            first;
  logic [COLS-1:0] cols;
  logic [COLS-1:0] mask;
  logic            want_low;
  logic            any_low;
  logic            stable;

  function automatic logic [ROWS-1:0] row_sel(input logic [RW-1:0] r);
    return ~(ROWS'(1) << r);
  endfunction

  keypad_debounce #(
    .COLS    (COLS),
    .DEB_CYC (DEB_CYC),
    .CW      (CW)
  ) u_deb (
    .clk      (clk),
    .rst      (rst),
    .key_v    (key_v),
    .col_mask (mask),
    .want_low (want_low),
    .cols     (cols),
    .any_low  (any_low),
    .stable   (stable)
  );

  // IDLE waits for any low column, HOLD waits for the latched column to go high.
  always_comb begin
    mask     = '0;
    want_low = 1'b1;
    case (state)
      S_IDLE: mask = '1;
      S_HOLD: begin
        mask     = COLS'(1) << col_q;
        want_low = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    hit_col = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!cols[c]) hit_col = CCW'(c);
    end
  end

  assign rpt_tgt = first ? CW'(RPT_DLY) : CW'(RPT_PER);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      row         <= '0;
      col_q       <= '0;
      cnt         <= '0;
      first       <= 1'b1;
      key_h       <= '0;
      key_valid   <= 1'b0;
      key_code    <= '0;
      key_down    <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_valid   <= 1'b0;
      key_release <= 1'b0;
      case (state)
        S_IDLE: begin
          key_h    <= '0;
          key_down <= 1'b0;
          if (stable) begin
            state <= S_SCAN;
            row   <= '0;
            cnt   <= '0;
            key_h <= row_sel('0);
          end
        end
        S_SCAN: begin
          if (cnt != CW'(SAMPLE_AT)) begin
            cnt <= cnt + CW'(1);
          end else begin
            cnt <= '0;
            if (any_low) begin
              state     <= S_HOLD;
              col_q     <= hit_col;
              key_code  <= CODE_W'(code_of(int'(row), int'(hit_col), COLS));
              key_valid <= 1'b1;
              key_down  <= 1'b1;
              first     <= 1'b1;
            end else if (row == RW'(ROWS - 1)) begin
              state <= S_IDLE;
              key_h <= '0;
            end else begin
              row   <= row + RW'(1);
              key_h <= row_sel(row + RW'(1));
            end
          end
        end
        S_HOLD: begin
          key_down <= 1'b1;
          if (stable) begin
            state       <= S_RELS;
            key_down    <= 1'b0;
            key_release <= 1'b1;
            cnt         <= '0;
          end else if (!rpt_en) begin
            cnt   <= '0;
            first <= 1'b1;
          end else if (cnt == rpt_tgt - CW'(1)) begin
            key_valid <= 1'b1;
            cnt       <= '0;
            first     <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_RELS: begin
          state    <= S_IDLE;
          key_down <= 1'b0;
          key_h    <= '0;
          cnt      <= '0;
        end
        default: begin
          state <= S_IDLE;
          key_h <= '0;
        end
      endcase
    end
  end

  // History shifts the cycle after each key_valid; a clear in that cycle wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_num <= '0;
    end else if (disp_clr) begin
      disp_num <= '0;
    end else if (key_valid) begin
      disp_num <= (disp_num << CODE_W) | DW'(key_code);
    end
  end

endmodule

// File: tb/tb_matrix_keypad_scanner.sv
// Randomized and directed bench for matrix_keypad_scanner with a resistive keypad model and a history model.
module tb_matrix_keypad_scanner;

  localparam int ROWS = 4, COLS = 4, DEB = 20, SET = 2, RDLY = 100, RPER = 30, DIG = 4, CWD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  key_v, key_h;
  logic        rpt_en = 1'b0, disp_clr = 1'b0;
  logic        key_valid, key_down, key_release;
  logic [3:0]  key_code;
  logic [15:0] disp_num;

  logic [4:0]  key_v35;
  logic [2:0]  key_h35;
  logic        kv35, kd35, kr35;
  logic [3:0]  kc35;
  logic [15:0] dn35;
  logic        k35_on = 1'b0;

  logic [1:0] k_on = 2'b00;
  int k_r[2];
  int k_c[2];

  int total = 0, bad = 0;
  int cyc = 0, rel_cnt = 0;
  int vt[$];
  int vc[$];
  int hist[$];

  always #5 clk = ~clk;

  matrix_keypad_scanner #(.ROWS(ROWS), .COLS(COLS), .DEB_CYC(DEB), .SETTLE(SET), .RPT_DLY(RDLY),
                          .RPT_PER(RPER), .DIGITS(DIG)) u4 (
    .clk(clk), .rst(rst), .key_v(key_v), .key_h(key_h), .rpt_en(rpt_en), .disp_clr(disp_clr),
    .key_valid(key_valid), .key_code(key_code), .key_down(key_down), .key_release(key_release),
    .disp_num(disp_num));

  matrix_keypad_scanner #(.ROWS(3), .COLS(5), .DEB_CYC(DEB), .SETTLE(SET), .RPT_DLY(RDLY),
                          .RPT_PER(RPER), .DIGITS(DIG)) u35 (
    .clk(clk), .rst(rst), .key_v(key_v35), .key_h(key_h35), .rpt_en(1'b0), .disp_clr(1'b0),
    .key_valid(kv35), .key_code(kc35), .key_down(kd35), .key_release(kr35), .disp_num(dn35));

  // A pressed key connects its row to its column: the column reads low only while its row is driven low.
  always_comb begin
    key_v = '1;
    for (int i = 0; i < 2; i++) begin
      if (k_on[i] && !key_h[k_r[i]]) key_v[k_c[i]] = 1'b0;
    end
  end

  always_comb begin
    key_v35 = '1;
    if (k35_on && !key_h35[2]) key_v35[4] = 1'b0;
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    if (key_valid) begin
      vt.push_back(cyc);
      vc.push_back(int'(key_code));
    end
    if (key_release) rel_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_vt(input int n, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (vt.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rel(input int n, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (rel_cnt >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [15:0] exp_disp();
    logic [15:0] v = '0;
    int n = hist.size();
    for (int i = (n > DIG) ? n - DIG : 0; i < n; i++) v = (v << CWD) | 16'(hist[i]);
    return v;
  endfunction

  // One clean press: expect exactly one key_valid with the scan code, then exactly one release pulse.
  task automatic press_check(input int r, input int c, input int hold, input string tag);
    int n0 = vt.size();
    int r0 = rel_cnt;
    bit ok;
    k_r[0] = r; k_c[0] = c; k_on[0] = 1'b1;
    wait_vt(n0 + 1, 200, ok);
    check({tag, "_seen"}, 32'(ok), 32'd1);
    if (ok) begin
      check({tag, "_code"}, 32'(vc[n0]), 32'(r * COLS + c));
      hist.push_back(r * COLS + c);
    end
    step(2);
    check({tag, "_down"}, 32'(key_down), 32'd1);
    step(hold);
    k_on[0] = 1'b0;
    wait_rel(r0 + 1, 100, ok);
    check({tag, "_rel"}, 32'(ok), 32'd1);
    step(3);
    check({tag, "_one_valid"}, 32'(vt.size()), 32'(n0 + 1));
    check({tag, "_one_rel"}, 32'(rel_cnt), 32'(r0 + 1));
  endtask

  initial begin
    bit ok;
    int n0, r0, nexp, nxt;
    int exp_off[$];

    k_r[0] = 0; k_c[0] = 0; k_r[1] = 0; k_c[1] = 0;

    // Reset state
    step(3);
    check("rst_key_h", 32'(key_h), 32'h0);
    check("rst_valid", 32'(key_valid), 32'h0);
    check("rst_down", 32'(key_down), 32'h0);
    check("rst_code", 32'(key_code), 32'h0);
    check("rst_disp", 32'(disp_num), 32'h0);
    rst = 1'b0;
    step(5);

    // Key 9 (row 2, col 1) held about 200 cycles without repeat
    n0 = vt.size(); r0 = rel_cnt;
    k_r[0] = 2; k_c[0] = 1; k_on[0] = 1'b1;
    wait_vt(n0 + 1, 200, ok);
    check("k9_seen", 32'(ok), 32'd1);
    if (ok) check("k9_code", 32'(vc[n0]), 32'd9);
    hist.push_back(9);
    step(5);
    check("k9_down", 32'(key_down), 32'd1);
    check("k9_row", 32'(key_h), 32'hb);
    step(165);
    k_on[0] = 1'b0;
    wait_rel(r0 + 1, 100, ok);
    check("k9_rel", 32'(ok), 32'd1);
    step(3);
    check("k9_one_valid", 32'(vt.size()), 32'(n0 + 1));
    check("k9_up", 32'(key_down), 32'd0);
    check("k9_disp", 32'(disp_num), 32'h0009);

    disp_clr = 1'b1; step(1); disp_clr = 1'b0; hist.delete();
    check("clr0", 32'(disp_num), 32'h0);

    press_check(0, 0, 20, "d0");
    press_check(1, 1, 20, "d5");
    press_check(2, 2, 20, "d10");
    press_check(3, 3, 20, "d15");
    check("disp_05af", 32'(disp_num), 32'h05af);
    press_check(0, 3, 20, "d3");
    check("disp_5af3", 32'(disp_num), 32'h5af3);
    disp_clr = 1'b1; step(1); disp_clr = 1'b0; hist.delete();
    check("clr1", 32'(disp_num), 32'h0);

    // Random presses, held too briefly to reach the first repeat
    for (int i = 0; i < 6; i++) begin
      rpt_en = 1'($urandom_range(0, 1));
      press_check(int'($urandom_range(0, ROWS - 1)), int'($urandom_range(0, COLS - 1)),
                  int'($urandom_range(10, 60)), "rand");
    end
    check("rand_disp", 32'(disp_num), 32'(exp_disp()));

    // Auto-repeat on key 6: release 180 cycles after the first pulse
    rpt_en = 1'b1;
    n0 = vt.size(); r0 = rel_cnt;
    k_r[0] = 1; k_c[0] = 2; k_on[0] = 1'b1;
    wait_vt(n0 + 1, 200, ok);
    check("rpt_seen", 32'(ok), 32'd1);
    step(180);
    k_on[0] = 1'b0;
    wait_rel(r0 + 1, 100, ok);
    check("rpt_rel", 32'(ok), 32'd1);
    exp_off.push_back(0);
    for (int t = RDLY; t < 180 + DEB; t += RPER) exp_off.push_back(t);
    check("rpt_count", 32'(vt.size() - n0), 32'(exp_off.size()));
    for (int i = 0; i < exp_off.size() && n0 + i < vt.size(); i++) begin
      check("rpt_off", 32'(vt[n0 + i] - vt[n0]), 32'(exp_off[i]));
      check("rpt_code", 32'(vc[n0 + i]), 32'd6);
      hist.push_back(6);
    end
    step(3);
    check("rpt_disp", 32'(disp_num), 32'(exp_disp()));

    // Dropping rpt_en just before the first repeat restarts the full delay
    n0 = vt.size(); r0 = rel_cnt;
    k_r[0] = 1; k_c[0] = 0; k_on[0] = 1'b1;
    wait_vt(n0 + 1, 200, ok);
    hist.push_back(4);
    step(90); rpt_en = 1'b0; step(5); rpt_en = 1'b1; step(55);
    k_on[0] = 1'b0;
    wait_rel(r0 + 1, 100, ok);
    nxt = 95 + RDLY;
    nexp = 1 + ((nxt < 150 + DEB) ? 1 : 0);
    check("rpt_restart", 32'(vt.size() - n0), 32'(nexp));
    rpt_en = 1'b0;
    step(5);

    // 15-cycle bounce on col 0 is rejected
    n0 = vt.size();
    k_r[0] = 0; k_c[0] = 0; k_on[0] = 1'b1;
    step(15);
    k_on[0] = 1'b0;
    step(60);
    check("bounce_valid", 32'(vt.size()), 32'(n0));
    check("bounce_idle", 32'(key_h), 32'h0);
    check("bounce_disp", 32'(disp_num), 32'(exp_disp()));

    // Keys 7 and 13 together: 7 first, 13 only after 7 releases
    n0 = vt.size(); r0 = rel_cnt;
    k_r[0] = 1; k_c[0] = 3; k_r[1] = 3; k_c[1] = 1; k_on = 2'b11;
    wait_vt(n0 + 1, 200, ok);
    check("two_seen", 32'(ok), 32'd1);
    if (ok) check("two_first", 32'(vc[n0]), 32'd7);
    step(40);
    check("two_hold_only7", 32'(vt.size()), 32'(n0 + 1));
    k_on[0] = 1'b0;
    wait_vt(n0 + 2, 200, ok);
    check("two_second_seen", 32'(ok), 32'd1);
    if (ok) check("two_second", 32'(vc[n0 + 1]), 32'd13);
    check("two_rel_between", 32'(rel_cnt), 32'(r0 + 1));
    k_on[1] = 1'b0;
    wait_rel(r0 + 2, 100, ok);
    check("two_rel2", 32'(ok), 32'd1);
    step(5);

    // Asynchronous reset while holding key 5
    n0 = vt.size();
    k_r[0] = 1; k_c[0] = 1; k_on[0] = 1'b1;
    wait_vt(n0 + 1, 200, ok);
    step(3);
    #2 rst = 1'b1;
    #1;
    check("arst_key_h", 32'(key_h), 32'h0);
    check("arst_down", 32'(key_down), 32'h0);
    check("arst_code", 32'(key_code), 32'h0);
    check("arst_disp", 32'(disp_num), 32'h0);
    k_on[0] = 1'b0;
    step(3);
    rst = 1'b0;
    hist.delete();
    step(5);

    // 3x5 build: key (2,4) -> 14
    k35_on = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (kv35) begin
        ok = 1'b1;
        check("k35_code", 32'(kc35), 32'd14);
        check("k35_row", 32'(key_h35), 32'h3);
      end
    end
    check("k35_seen", 32'(ok), 32'd1);
    k35_on = 1'b0;
    step(40);
    check("k35_up", 32'(kd35), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
